sync_fifo_rd_adapter: RTL and testbench

Read-side adapter that drains a `sync_fifo` instance and presents its contents as a valid/ready stream. It generates the FIFO read enable and absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer. This delivers one beat per cycle under continuous `m_ready` and never loses a beat under backpressure. It sits between a `sync_fifo` and any valid/ready consumer in the same clock domain.

---
 rtl/sync_fifo_rd_adapter.sv | 130 +++++++++++++
 tb/tb_sync_fifo_rd_adapter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_rd_adapter.sv
// Purpose : drains a sync_fifo and presents its read data as a valid/ready stream via a 2-entry skid buffer.
// Latency : fifo_rd_en in cycle N -> fifo_data_vld in N+1 -> m_valid with that beat in N+2; 1 beat/cycle sustained.
// Backpr. : holds at most 2 beats; fifo_rd_en drops once buffered + in-flight beats reach 2, so no beat is lost.
//
// Ports:
//   clk, rstn                     single clock, asynchronous active-low reset
//   fifo_empty / fifo_rd_en       FIFO empty flag in, read enable out
//   fifo_data_vld / fifo_data     FIFO read data, valid one cycle after an accepted read
//   m_valid / m_ready / m_data    output stream; m_data held stable while stalled
//   ovf_err                       sticky: a read beat arrived with no buffer space (dropped)
//   xfer_cnt                      handshake counter, present only when FIFO_RD_XFER_CNT_EN is defined
//
// Optional feature macro: FIFO_RD_XFER_CNT_EN (adds xfer_cnt port and counter).

module sync_fifo_rd_adapter #(
    parameter int DATA_WID = 8,
    parameter int CNT_WID  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic                fifo_data_vld,
    input  logic [DATA_WID-1:0] fifo_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_WID-1:0] m_data,
    output logic                ovf_err
`ifdef FIFO_RD_XFER_CNT_EN
    ,
    output logic [CNT_WID-1:0]  xfer_cnt
`endif
);

    // Skid buffer storage and bookkeeping.
    logic [DATA_WID-1:0] mem_q [2];
    logic [DATA_WID-1:0] mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                inflight_q, inflight_d;
    logic                ovf_err_q, ovf_err_d;

    logic                pop;
    logic                push;
    logic                room;
    logic                wr;
    logic [2:0]          credit;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = mem_q[rd_ptr_q];
    assign ovf_err = ovf_err_q;

    always_comb begin
        pop  = m_valid && m_ready;
        push = fifo_data_vld;
        // A full buffer still accepts a beat when the head leaves in the same cycle:
        // the slot being written is the one being read out, so the old value is consumed first.
        room = (count_q != 2'd2) || pop;
        wr   = push && room;

        // Occupancy the buffer will have once everything already requested has landed.
        // Pop is only possible with count >= 1, so this never goes negative. Using the
        // current pop keeps the m_ready -> fifo_rd_en path combinational for full throughput.
        credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !fifo_empty && (credit < 3'd2);
        inflight_d = fifo_rd_en;

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (wr) begin
            mem_d[wr_ptr_q] = fifo_data;
        end

        wr_ptr_d = wr_ptr_q ^ wr;
        rd_ptr_d = rd_ptr_q ^ pop;

        count_d = count_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        ovf_err_d = ovf_err_q || (push && !room);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

`ifdef FIFO_RD_XFER_CNT_EN
    logic [CNT_WID-1:0] xfer_cnt_q, xfer_cnt_d;

    // Wraps naturally modulo 2^CNT_WID.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_adapter.sv
// Purpose : randomized and directed scoreboard bench for sync_fifo_rd_adapter with a queue-based FIFO model.
// Latency : expected beats are queued at FIFO write time and popped by a monitor on each output handshake.
// Backpr. : m_ready is driven by the stimulus (held, stalled or random); the monitor also checks hold stability.

module tb_sync_fifo_rd_adapter;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          fifo_data_vld;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ovf_err;
`ifdef FIFO_RD_XFER_CNT_EN
    logic [CW-1:0] xfer_cnt;
`endif

    // FIFO model outputs and an override used to inject a stray read beat.
    logic          mdl_vld;
    logic [DW-1:0] mdl_dat;
    logic          frc_vld = 1'b0;
    logic [DW-1:0] frc_dat = '0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_dat = '0;

    assign fifo_data_vld = mdl_vld | frc_vld;
    assign fifo_data     = frc_vld ? frc_dat : mdl_dat;

    always #5 clk = ~clk;

    sync_fifo_rd_adapter #(.DATA_WID(DW), .CNT_WID(CW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_vld (fifo_data_vld),
        .fifo_data     (fifo_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .ovf_err       (ovf_err)
`ifdef FIFO_RD_XFER_CNT_EN
        ,
        .xfer_cnt      (xfer_cnt)
`endif
    );

    // Behavioural sync_fifo: registered empty flag, read data valid one cycle after rd_en.
    logic [DW-1:0] fq[$];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fq.delete();
            mdl_vld    <= 1'b0;
            mdl_dat    <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                mdl_dat <= fq.pop_front();
                mdl_vld <= 1'b1;
            end else begin
                mdl_vld <= 1'b0;
            end
            if (wr_en) fq.push_back(wr_dat);
            fifo_empty <= (fq.size() == 0);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard and monitor.
    logic [DW-1:0] exp_q[$];
    int            rd_cyc[$];
    int            pop_cyc[$];
    int            pops = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall <= 1'b0;
            pops       <= 0;
        end else begin
            chk("rd_en_while_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (prev_stall) begin
                chk("hold_valid", {31'b0, m_valid}, 32'd1);
                chk("hold_data", {24'b0, m_data}, {24'b0, prev_dat});
            end
            if (m_valid && m_ready) begin
                pop_cyc.push_back(cyc);
                pops <= pops + 1;
                if (exp_q.size() == 0)
                    chk("beat_expected", exp_q.size(), 32'd1);
                else
                    chk("beat_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
            end
            prev_stall <= m_valid && !m_ready;
            prev_dat   <= m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic [DW-1:0] d);
        wr_en  = 1'b1;
        wr_dat = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        wr_en   = 1'b0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1 rstn = 1'b0;
        #20;
        // Reset state with FIFO idle.
        chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", {24'b0, m_data}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_err}, 32'd0);
`ifdef FIFO_RD_XFER_CNT_EN
        chk("rst_xfer", {16'b0, xfer_cnt}, 32'd0);
`endif
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("idle_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        chk("idle_m_valid", {31'b0, m_valid}, 32'd0);

        // Streaming with m_ready held high.
        m_ready = 1'b1;
        rd_cyc.delete();
        pop_cyc.delete();
        for (int i = 0; i < 7; i++) write_beat(8'h11 + 8'(i));
        drain(100);
        chk("stream_rd_cnt", rd_cyc.size(), 32'd7);
        chk("stream_rd_span", rd_cyc[6] - rd_cyc[0], 32'd6);
        chk("stream_out_cnt", pop_cyc.size(), 32'd7);
        chk("stream_latency", pop_cyc[0] - rd_cyc[0], 32'd2);
        chk("stream_out_span", pop_cyc[6] - pop_cyc[0], 32'd6);
`ifdef FIFO_RD_XFER_CNT_EN
        chk("stream_xfer", {16'b0, xfer_cnt}, 32'd7);
`endif

        // Backpressure: 10 stalled cycles while 7 beats are loaded.
        m_ready = 1'b0;
        rd_cyc.delete();
        for (int i = 0; i < 7; i++) write_beat(8'h11 + 8'(i));
        repeat (3) tick();
        chk("bp_reads", rd_cyc.size(), 32'd2);
        chk("bp_valid", {31'b0, m_valid}, 32'd1);
        chk("bp_head", {24'b0, m_data}, 32'h11);
        drain(100);
        chk("bp_ovf", {31'b0, ovf_err}, 32'd0);
`ifdef FIFO_RD_XFER_CNT_EN
        chk("bp_xfer", {16'b0, xfer_cnt}, 32'd14);
`endif

        // Random write and m_ready activity over 200 beats.
        begin
            int sent = 0;
            int n = 0;
            while ((sent < 200 || exp_q.size() != 0) && n < 4000) begin
                m_ready = 1'($urandom % 2);
                if (sent < 200 && ($urandom % 2) == 1) begin
                    wr_en  = 1'b1;
                    wr_dat = 8'($urandom);
                    exp_q.push_back(wr_dat);
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
                n++;
            end
            wr_en = 1'b0;
        end
        drain(100);
        chk("rand_ovf", {31'b0, ovf_err}, 32'd0);
`ifdef FIFO_RD_XFER_CNT_EN
        chk("rand_xfer", {16'b0, xfer_cnt}, 32'd214);
`endif

        // Forced overflow: stray beat into a full, stalled buffer.
        m_ready = 1'b0;
        write_beat(8'h21);
        write_beat(8'h22);
        repeat (4) tick();
        chk("ovf_pre_valid", {31'b0, m_valid}, 32'd1);
        frc_vld = 1'b1;
        frc_dat = 8'hAA;
        tick();
        frc_vld = 1'b0;
        chk("ovf_rise", {31'b0, ovf_err}, 32'd1);
        repeat (3) tick();
        chk("ovf_sticky", {31'b0, ovf_err}, 32'd1);
        chk("ovf_head", {24'b0, m_data}, 32'h21);
        drain(50);
        chk("ovf_after_drain", {31'b0, ovf_err}, 32'd1);

        // Reset in the middle of a stalled stream.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_beat(8'h31 + 8'(i));
        repeat (2) tick();
        chk("mid_pre_valid", {31'b0, m_valid}, 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, m_valid}, 32'd0);
        chk("mid_rst_data", {24'b0, m_data}, 32'd0);
        chk("mid_rst_ovf", {31'b0, ovf_err}, 32'd0);
        exp_q.delete();
        repeat (3) tick();
        rstn = 1'b1;
        m_ready = 1'b1;
        repeat (6) tick();
        chk("mid_no_stale", {31'b0, m_valid}, 32'd0);
        for (int i = 0; i < 3; i++) write_beat(8'h41 + 8'(i));
        drain(50);
`ifdef FIFO_RD_XFER_CNT_EN
        chk("mid_xfer", {16'b0, xfer_cnt}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
